// File: rtl/dom_stream_sequencer_if.sv
// Signal bundle between the character source, the tag parser and the layout stage
// on one side and dom_stream_sequencer on the other.
interface dom_stream_sequencer_if #(
    parameter int DEPTH_W = 4,
    parameter int TAG_W   = 3,
    parameter int ATTR_W  = 4
);
    // Both streams (in_* and ev_*) use strict valid/ready: a beat moves on a rising
    // clock edge where valid && ready; valid never waits on ready, and payload holds
    // while valid is high and ready is low.
    logic [7:0]         in_char;
    logic               in_valid;
    logic               in_ready;
    logic               restart;

    logic               ep_enable;
    logic [7:0]         ep_char;
    logic [TAG_W-1:0]   ep_tag;
    logic               ep_closing;
    logic               ep_has_attr;

    logic               ev_valid;
    logic               ev_ready;
    logic [1:0]         ev_type;
    logic [TAG_W-1:0]   ev_tag;
    logic [7:0]         ev_char;
    logic [DEPTH_W-1:0] ev_depth;
    logic [ATTR_W-1:0]  ev_attrs;

    logic [DEPTH_W-1:0] depth;
    logic               error;
    logic               doc_done;
    logic [1:0]         dbg_state;

    modport master (
        input  in_char, in_valid, restart, ep_tag, ep_closing, ep_has_attr, ev_ready,
        output in_ready, ep_enable, ep_char, ev_valid, ev_type, ev_tag, ev_char,
               ev_depth, ev_attrs, depth, error, doc_done, dbg_state
    );

    modport slave (
        output in_char, in_valid, restart, ep_tag, ep_closing, ep_has_attr, ev_ready,
        input  in_ready, ep_enable, ep_char, ev_valid, ev_type, ev_tag, ev_char,
               ev_depth, ev_attrs, depth, error, doc_done, dbg_state
    );
endinterface

// File: rtl/dom_stream_sequencer.sv
// Splits a document character stream into markup and text, gates the tag parser,
// matches open/close tags on a stack and emits one registered event per boundary.
module dom_stream_sequencer #(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 4,
    parameter int TAG_W   = 3,
    parameter int ATTR_W  = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    dom_stream_sequencer_if.master bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
    localparam logic [7:0] CH_LT = 8'h3C;
    localparam logic [7:0] CH_GT = 8'h3E;
    localparam logic [1:0] EV_OPEN  = 2'd0;
    localparam logic [1:0] EV_CLOSE = 2'd1;
    localparam logic [1:0] EV_TEXT  = 2'd2;
    localparam logic [1:0] EV_ERROR = 2'd3;

    typedef enum logic [1:0] {
        S_TEXT  = 2'd0,
        S_TAG   = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [ATTR_W-1:0]  attr_q, attr_d, attr_cnt;
    logic               error_q, error_d;
    logic               doc_done_q, doc_done_d;
    logic [TAG_W-1:0]   stack_q [DEPTH];

    logic               ev_valid_q, ev_valid_d;
    logic [1:0]         ev_type_q, ev_type_d;
    logic [TAG_W-1:0]   ev_tag_q, ev_tag_d;
    logic [7:0]         ev_char_q, ev_char_d;
    logic [DEPTH_W-1:0] ev_depth_q, ev_depth_d;
    logic [ATTR_W-1:0]  ev_attrs_q, ev_attrs_d;

    logic               xfer, is_lt, is_gt, tag_err;
    logic               push, pop, err_set, attr_clr, ev_load;
    logic [IDX_W-1:0]   top_idx, push_idx;
    logic [TAG_W-1:0]   top_tag;
    logic [1:0]         ev_type_n;
    logic [TAG_W-1:0]   ev_tag_n;
    logic [7:0]         ev_char_n;
    logic [DEPTH_W-1:0] ev_depth_n;
    logic [ATTR_W-1:0]  ev_attrs_n;

    assign bus.in_ready = !ev_valid_q || bus.ev_ready;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign is_lt        = (bus.in_char == CH_LT);
    assign is_gt        = (bus.in_char == CH_GT);

    assign top_idx  = IDX_W'(depth_q - DEPTH_W'(1));
    assign push_idx = IDX_W'(depth_q);
    assign top_tag  = stack_q[top_idx];

    // top_tag is garbage at depth 0, but the depth test masks it.
    assign tag_err = bus.ep_closing ? ((depth_q == '0) || (top_tag != bus.ep_tag))
                                    : (depth_q == DEPTH_MAX);

    // An attribute pulse coinciding with '>' is already folded in here.
    assign attr_cnt = (bus.ep_has_attr && (attr_q != '1)) ? attr_q + ATTR_W'(1) : attr_q;

    // FSM: state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_TEXT;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.restart) begin
            state_d = S_TEXT;
        end else if (xfer) begin
            case (state_q)
                S_TEXT:  if (is_lt) state_d = S_TAG;
                S_TAG:   if (is_gt) state_d = tag_err ? S_ERROR : S_TEXT;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM: outputs and per-character actions
    always_comb begin
        bus.ep_enable = (state_q == S_TAG);
        bus.ep_char   = 8'h00;
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;
        attr_clr   = 1'b0;
        ev_load    = 1'b0;
        ev_type_n  = EV_OPEN;
        ev_tag_n   = '0;
        ev_char_n  = 8'h00;
        ev_depth_n = depth_q;
        ev_attrs_n = '0;
        if (xfer && state_q == S_TAG) bus.ep_char = bus.in_char;
        if (xfer && !bus.restart) begin
            case (state_q)
                S_TEXT: begin
                    if (is_lt) begin
                        attr_clr = 1'b1;
                    end else if (depth_q != '0) begin
                        ev_load   = 1'b1;
                        ev_type_n = EV_TEXT;
                        ev_char_n = bus.in_char;
                    end
                end
                S_TAG: begin
                    if (is_gt) begin
                        ev_load = 1'b1;
                        if (tag_err) begin
                            err_set   = 1'b1;
                            ev_type_n = EV_ERROR;
                            ev_tag_n  = bus.ep_closing ? bus.ep_tag : '0;
                        end else if (!bus.ep_closing) begin
                            push       = 1'b1;
                            ev_type_n  = EV_OPEN;
                            ev_tag_n   = bus.ep_tag;
                            ev_depth_n = depth_q + DEPTH_W'(1);
                            ev_attrs_n = attr_cnt;
                        end else begin
                            pop        = 1'b1;
                            ev_type_n  = EV_CLOSE;
                            ev_tag_n   = bus.ep_tag;
                            ev_depth_n = depth_q - DEPTH_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath next values
    always_comb begin
        depth_d    = depth_q;
        attr_d     = attr_q;
        error_d    = error_q;
        doc_done_d = 1'b0;
        ev_valid_d = ev_valid_q;
        ev_type_d  = ev_type_q;
        ev_tag_d   = ev_tag_q;
        ev_char_d  = ev_char_q;
        ev_depth_d = ev_depth_q;
        ev_attrs_d = ev_attrs_q;
        if (bus.restart) begin
            depth_d = '0;
            attr_d  = '0;
            error_d = 1'b0;
        end else begin
            if (push)     depth_d = depth_q + DEPTH_W'(1);
            else if (pop) depth_d = depth_q - DEPTH_W'(1);
            if (err_set)  error_d = 1'b1;
            if (state_q == S_TAG) attr_d = attr_cnt;
            else if (attr_clr)    attr_d = '0;
        end
        // A pending event survives restart; only the consumer clears it.
        if (ev_load) begin
            ev_valid_d = 1'b1;
            ev_type_d  = ev_type_n;
            ev_tag_d   = ev_tag_n;
            ev_char_d  = ev_char_n;
            ev_depth_d = ev_depth_n;
            ev_attrs_d = ev_attrs_n;
            doc_done_d = pop && (depth_q == DEPTH_W'(1));
        end else if (bus.ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            depth_q    <= '0;
            attr_q     <= '0;
            error_q    <= 1'b0;
            doc_done_q <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_type_q  <= 2'd0;
            ev_tag_q   <= '0;
            ev_char_q  <= 8'h00;
            ev_depth_q <= '0;
            ev_attrs_q <= '0;
        end else begin
            depth_q    <= depth_d;
            attr_q     <= attr_d;
            error_q    <= error_d;
            doc_done_q <= doc_done_d;
            ev_valid_q <= ev_valid_d;
            ev_type_q  <= ev_type_d;
            ev_tag_q   <= ev_tag_d;
            ev_char_q  <= ev_char_d;
            ev_depth_q <= ev_depth_d;
            ev_attrs_q <= ev_attrs_d;
        end
    end

    // Stack contents need no reset: depth alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (push) stack_q[push_idx] <= bus.ep_tag;
    end

    assign bus.ev_valid  = ev_valid_q;
    assign bus.ev_type   = ev_type_q;
    assign bus.ev_tag    = ev_tag_q;
    assign bus.ev_char   = ev_char_q;
    assign bus.ev_depth  = ev_depth_q;
    assign bus.ev_attrs  = ev_attrs_q;
    assign bus.depth     = depth_q;
    assign bus.error     = error_q;
    assign bus.doc_done  = doc_done_q;
    assign bus.dbg_state = state_q;
endmodule
